// File: rtl/fifo_rd_packer.sv
// Read-side consumer of asyncfifo: pops FWFT entries in the rclk domain and packs
// PACK_N of them little-endian into one word on a valid/ready master port.
module fifo_rd_packer #(
    parameter int DSIZE   = 8,
    parameter int PACK_N  = 4,
    parameter int TIMEOUT = 0
) (
    input  logic                           rclk,
    input  logic                           rrst_n,
    input  logic                           rempty,
    input  logic [DSIZE-1:0]               rdata,
    output logic                           rinc,
    input  logic                           flush,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [DSIZE*PACK_N-1:0]        m_data,
    output logic [$clog2(PACK_N+1)-1:0]    m_cnt,
    output logic                           busy
);

    localparam int CW = $clog2(PACK_N + 1);
    localparam int IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int WW = DSIZE * PACK_N;
    localparam logic [CW-1:0] LAST      = CW'(PACK_N - 1);
    localparam logic [IW-1:0] IDLE_LAST = (TIMEOUT > 0) ? IW'(TIMEOUT - 1) : '0;
    localparam logic [IW-1:0] IDLE_MAX  = IW'(TIMEOUT);

    logic [WW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          valid_q, valid_d;
    logic [WW-1:0] data_q, data_d;
    logic [CW-1:0] mcnt_q, mcnt_d;

    logic out_free, pop, emit, idle_inc, timeout_hit;

    assign out_free    = !valid_q | m_ready;
    // The final pop of a word needs a free output slot; earlier pops only need data.
    assign pop         = rrst_n & !rempty & !pend_q & ((cnt_q < LAST) | out_free);
    assign emit        = pend_q & (cnt_q != '0) & out_free;
    assign idle_inc    = (TIMEOUT > 0) & rempty & (cnt_q != '0) & !pend_q & (idle_q != IDLE_MAX);
    assign timeout_hit = idle_inc & (idle_q == IDLE_LAST);

    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        idle_d  = idle_q;
        valid_d = valid_q & !m_ready;
        data_d  = data_q;
        mcnt_d  = mcnt_q;

        if (pop) begin
            for (int unsigned i = 0; i < PACK_N; i++) begin
                if (cnt_q == CW'(i)) acc_d[i*DSIZE +: DSIZE] = rdata;
            end
            if (cnt_q == LAST) begin
                data_d  = acc_d;
                mcnt_d  = CW'(PACK_N);
                valid_d = 1'b1;
                cnt_d   = '0;
                acc_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (emit) begin
            data_d  = acc_q;
            mcnt_d  = cnt_q;
            valid_d = 1'b1;
            cnt_d   = '0;
            acc_d   = '0;
        end

        // Pulses arriving while a flush is pending are absorbed.
        if (pend_q) begin
            if (cnt_q == '0 || out_free) pend_d = 1'b0;
        end else if (flush || timeout_hit) begin
            pend_d = 1'b1;
        end

        if (pop || cnt_q == '0) idle_d = '0;
        else if (idle_inc)      idle_d = idle_q + IW'(1);
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            idle_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            mcnt_q  <= '0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            idle_q  <= idle_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            mcnt_q  <= mcnt_d;
        end
    end

    assign rinc    = pop;
    assign m_valid = valid_q;
    assign m_data  = data_q;
    assign m_cnt   = mcnt_q;
    assign busy    = (cnt_q != '0) | pend_q | valid_q;

endmodule
